// File: rtl/sweep_pkg.sv
// Shared types for the sweep sequencer: FSM state encoding and sweep mode values.
package sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_BOUNCE  = 1'b1;

endpackage

// File: rtl/sweep_prescaler.sv
// Step-rate prescaler: counts 0..div and raises tick on the terminal count, then wraps.
module sweep_prescaler #(
  parameter int unsigned DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  localparam logic [DIVW-1:0] One = DIVW'(1);

  logic [DIVW-1:0] cnt_q;

  assign tick = (cnt_q == div);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + One;
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Up/down sweep sequencer: one-shot or triangle sweep of count between lo and hi limits,
// stepping every div+1 cycles, with a valid/ready config port and start/stop strobes.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIVW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [DIVW-1:0]  cfg_div,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             period,
  output logic             err
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q;
  logic [WIDTH-1:0] lo_q, hi_q, count_q;
  logic [DIVW-1:0]  div_q;
  logic             mode_q;
  logic             dir_q, busy_q, done_q, period_q, err_q;

  logic             cfg_fire;
  logic [WIDTH-1:0] eff_lo, eff_hi;
  logic             tick;

  assign cfg_ready = (state_q == StIdle);
  assign cfg_fire  = cfg_valid && cfg_ready;

  // A config word arriving with start takes effect for that start.
  assign eff_lo = cfg_fire ? cfg_lo : lo_q;
  assign eff_hi = cfg_fire ? cfg_hi : hi_q;

  // Held clear while idle so the first step lands div+1 cycles after start.
  sweep_prescaler #(
    .DIVW(DIVW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == StIdle),
    .div  (div_q),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '1;
      div_q    <= '0;
      mode_q   <= MODE_ONESHOT;
      count_q  <= '0;
      dir_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      period_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      period_q <= 1'b0;
      err_q    <= 1'b0;

      if (cfg_fire) begin
        lo_q   <= cfg_lo;
        hi_q   <= cfg_hi;
        div_q  <= cfg_div;
        mode_q <= cfg_mode;
      end

      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            if (eff_lo > eff_hi) begin
              err_q <= 1'b1;
            end else begin
              count_q <= eff_lo;
              dir_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StUp;
            end
          end
        end
        StUp: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (tick) begin
            if (count_q < hi_q) begin
              count_q <= count_q + One;
            end else if (mode_q == MODE_ONESHOT) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else if (lo_q == hi_q) begin
              period_q <= 1'b1;
            end else begin
              count_q <= hi_q - One;
              dir_q   <= 1'b0;
              state_q <= StDown;
            end
          end
        end
        StDown: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (tick) begin
            if (count_q > lo_q) begin
              count_q <= count_q - One;
            end else begin
              count_q  <= lo_q + One;
              dir_q    <= 1'b1;
              period_q <= 1'b1;
              state_q  <= StUp;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign count  = count_q;
  assign dir    = dir_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign period = period_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: each scenario queues the expected per-cycle output word
// and compares it against the DUT one cycle at a time.
module tb_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_lo = '0;
  logic [7:0] cfg_hi = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_mode = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] count;
  logic       dir, busy, done, period, err;

  always #5 clk = ~clk;

  sweep_ctrl #(
    .WIDTH(8),
    .DIVW (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_lo   (cfg_lo),
    .cfg_hi   (cfg_hi),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .start    (start),
    .stop     (stop),
    .count    (count),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .period   (period),
    .err      (err)
  );

  // Observed word: {count, dir, busy, done, period, err, cfg_ready}
  logic [13:0] obs;
  assign obs = {count, dir, busy, done, period, err, cfg_ready};

  logic [13:0] exp_q[$];
  logic [13:0] e;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          hold_cfg = 1'b0;

  // cfg_ready is expected high exactly when not busy.
  function automatic logic [13:0] ex(int c, bit d, bit b, bit dn, bit p, bit er);
    logic [7:0] cc;
    cc = c[7:0];
    return {cc, d, b, dn, p, er, ~b};
  endfunction

  task automatic launch(int lo, int hi, int dv, bit md, bit with_cfg);
    cfg_lo    = lo[7:0];
    cfg_hi    = hi[7:0];
    cfg_div   = dv[7:0];
    cfg_mode  = md;
    cfg_valid = with_cfg;
    start     = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_q.push_back(ex(0, 1, 0, 0, 0, 0));
    exp_q.push_back(ex(0, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      if (!hold_cfg) cfg_valid = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL reset: got %h expected %h", obs, e);
      end
    end
  endtask

  task automatic test_oneshot();
    launch(2, 5, 0, 0, 1);
    for (int c = 2; c <= 5; c++) exp_q.push_back(ex(c, 1, 1, 0, 0, 0));
    exp_q.push_back(ex(5, 1, 0, 1, 0, 0));
    exp_q.push_back(ex(5, 1, 0, 0, 0, 0));
    exp_q.push_back(ex(5, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      if (!hold_cfg) cfg_valid = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL oneshot: got %h expected %h", obs, e);
      end
    end
  endtask

  task automatic test_bounce_prescale();
    int seq_c[13] = '{1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 2, 2, 3};
    bit seq_d[13] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    launch(1, 3, 1, 1, 1);
    for (int i = 0; i < 13; i++) exp_q.push_back(ex(seq_c[i], seq_d[i], 1, 0, (i == 10), 0));
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        stop = 1'b1;
        exp_q.push_back(ex(3, 1, 0, 0, 0, 0));
      end
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        if (!hold_cfg) cfg_valid = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin
          n_bad++; $display("FAIL bounce: got %h expected %h", obs, e);
        end
      end
    end
  endtask

  task automatic test_degenerate();
    for (int phase = 0; phase < 3; phase++) begin
      if (phase == 0) begin
        launch(7, 7, 0, 1, 1);
        exp_q.push_back(ex(7, 1, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) exp_q.push_back(ex(7, 1, 1, 0, 1, 0));
      end else if (phase == 1) begin
        stop = 1'b1;
        exp_q.push_back(ex(7, 1, 0, 0, 0, 0));
      end else begin
        launch(9, 4, 0, 0, 1);
        exp_q.push_back(ex(7, 1, 0, 0, 0, 1));
        exp_q.push_back(ex(7, 1, 0, 0, 0, 0));
      end
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        if (!hold_cfg) cfg_valid = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin
          n_bad++; $display("FAIL degenerate: got %h expected %h", obs, e);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int seq_c[7] = '{253, 254, 255, 254, 253, 254, 255};
    bit seq_d[7] = '{1, 1, 1, 0, 0, 1, 1};
    launch(253, 255, 0, 1, 1);
    for (int i = 0; i < 7; i++) exp_q.push_back(ex(seq_c[i], seq_d[i], 1, 0, (i == 5), 0));
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        stop = 1'b1;
        exp_q.push_back(ex(255, 1, 0, 0, 0, 0));
      end
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        if (!hold_cfg) cfg_valid = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin
          n_bad++; $display("FAIL boundary: got %h expected %h", obs, e);
        end
      end
    end
  endtask

  task automatic test_stop_start_rst();
    for (int phase = 0; phase < 6; phase++) begin
      case (phase)
        0: begin
          launch(2, 9, 0, 0, 1);
          for (int c = 2; c <= 4; c++) exp_q.push_back(ex(c, 1, 1, 0, 0, 0));
        end
        1: begin
          stop = 1'b1;
          exp_q.push_back(ex(4, 1, 0, 0, 0, 0));
        end
        2: begin
          start = 1'b1; stop = 1'b1;
          exp_q.push_back(ex(4, 1, 0, 0, 0, 0));
          exp_q.push_back(ex(4, 1, 0, 0, 0, 0));
        end
        3: begin
          launch(0, 0, 0, 0, 0);
          exp_q.push_back(ex(2, 1, 1, 0, 0, 0));
          exp_q.push_back(ex(3, 1, 1, 0, 0, 0));
        end
        4: begin
          start = 1'b1;
          exp_q.push_back(ex(4, 1, 1, 0, 0, 0));
        end
        default: begin
          rst = 1'b1;
          exp_q.push_back(ex(0, 1, 0, 0, 0, 0));
          exp_q.push_back(ex(0, 1, 0, 0, 0, 0));
        end
      endcase
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        if (!hold_cfg) cfg_valid = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin
          n_bad++; $display("FAIL stop_start_rst ph%0d: got %h expected %h", phase, obs, e);
        end
      end
    end
  endtask

  task automatic test_cfg_busy();
    for (int phase = 0; phase < 5; phase++) begin
      case (phase)
        0: begin
          launch(0, 2, 0, 0, 1);
          exp_q.push_back(ex(0, 1, 1, 0, 0, 0));
        end
        1: begin
          // New word held valid for the whole sweep; it must wait for idle.
          cfg_valid = 1'b1; cfg_lo = 8'd5; cfg_hi = 8'd6; cfg_div = 8'd0; cfg_mode = 1'b1;
          hold_cfg = 1'b1;
          exp_q.push_back(ex(1, 1, 1, 0, 0, 0));
          exp_q.push_back(ex(2, 1, 1, 0, 0, 0));
          exp_q.push_back(ex(2, 1, 0, 1, 0, 0));
        end
        2: begin
          hold_cfg = 1'b0;
          exp_q.push_back(ex(2, 1, 0, 0, 0, 0));
        end
        3: begin
          launch(0, 0, 0, 0, 0);
          exp_q.push_back(ex(5, 1, 1, 0, 0, 0));
          exp_q.push_back(ex(6, 1, 1, 0, 0, 0));
          exp_q.push_back(ex(5, 0, 1, 0, 0, 0));
          exp_q.push_back(ex(6, 1, 1, 0, 1, 0));
        end
        default: begin
          stop = 1'b1;
          exp_q.push_back(ex(6, 1, 0, 0, 0, 0));
        end
      endcase
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        if (!hold_cfg) cfg_valid = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin
          n_bad++; $display("FAIL cfg_busy ph%0d: got %h expected %h", phase, obs, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_bounce_prescale();
    test_degenerate();
    test_boundary();
    test_stop_start_rst();
    test_cfg_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Sequencer for an up/down count datapath. Sweeps a WIDTH-bit count between programmable low and high limits at a programmable step rate, either once (low→high) or continuously (triangle bounce). Sits between a register/config master, which uses a valid/ready config port plus start/stop strobes, and downstream consumers of `count`/`dir`, such as DAC ramps, PWM references or scan addresses.

## Interface
- `WIDTH`, 8: count and limit width.
- `DIVW`, 8: prescaler width.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1: config word valid.
- `cfg_ready` out 1: config accepted; high exactly when state is IDLE.
- `cfg_lo` in WIDTH: sweep low limit.
- `cfg_hi` in WIDTH: sweep high limit.
- `cfg_div` in DIVW: step every `cfg_div`+1 cycles.
- `cfg_mode` in 1: 0 = one-shot, 1 = bounce.
- `start` in 1: begin sweep (level-sampled; acts only in IDLE).
- `stop` in 1: abort sweep (acts only in UP/DOWN).
- `count` out WIDTH: current count.
- `dir` out 1: 1 = counting up, 0 = down.
- `busy` out 1: state is UP or DOWN.
- `done` out 1: one-cycle pulse at one-shot completion.
- `period` out 1: one-cycle pulse on each bounce turnaround at lo.
- `err` out 1: one-cycle pulse on rejected start.

## Operation
- Config registers: lo, hi, div, mode. Loaded on `cfg_valid && cfg_ready`. Reset values: lo=0, hi=all-ones, div=0, mode=0.
- States are IDLE, UP, DOWN. Reset → IDLE.
- IDLE + start:
  - Effective config is this cycle's cfg inputs if a config handshake also occurs this cycle, otherwise the registers.
  - If lo > hi: pulse `err`, stay IDLE, count unchanged.
  - Else: count←lo, dir←1, prescaler←0, go UP.
- Prescaler counts 0..div. `tick` = (prescaler == div), after which prescaler wraps to 0. div=0 gives a tick every cycle. Count changes only on tick.
- UP on tick:
  - count<hi: count+1.
  - count==hi, mode 0: pulse `done`, go IDLE, count holds hi.
  - count==hi, mode 1: go DOWN, dir←0, count←hi−1. If lo==hi, count holds and `period` pulses; state stays UP.
- DOWN on tick:
  - count>lo: count−1.
  - count==lo: go UP, dir←1, count←lo+1, pulse `period`.
- Count never wraps. Arithmetic is WIDTH bits, and limits bound every step; hi=all-ones is legal.
- stop in UP/DOWN: next state IDLE, count and dir hold, no `done`. stop in IDLE is ignored.
- start and stop together:
  - In IDLE, stop wins: no start, no err.
  - While running, start is ignored.
- Config while busy: `cfg_ready`=0, and the held word is accepted once IDLE.
- `rst` mid-sweep: the next cycle is IDLE with all reset values. A pulse in flight is dropped.

## Timing
- Reset values: count=0, dir=1, busy=0, done=0, period=0, err=0. `cfg_ready`=1 from the first cycle after reset.
- start sampled at edge T: count=lo, busy=1 after T. The first step is visible after edge T+div+1.
- Step cadence is exactly div+1 cycles, including turnarounds.
- `done`: asserted for the cycle following the tick at count==hi. busy falls and `cfg_ready` rises in the same cycle.
- `err` and `period` are registered, one-cycle, coincident with the state update.
- All outputs are registered, except `cfg_ready`, which is decoded from the state register.

## Structure
- Shared package `sweep_pkg`: state enum (IDLE, UP, DOWN), mode encodings (MODE_ONESHOT=0, MODE_BOUNCE=1).
- One sub-module: `sweep_prescaler` (DIVW counter, inputs clear/div, output tick). The FSM and count datapath stay in `sweep_ctrl`.
- Target size: 150–250 lines total.

## Test plan
- One-shot: lo=2, hi=5, div=0, mode 0, start → count 2,3,4,5 on consecutive cycles; `done` for 1 cycle next, busy→0, count stays 5.
- Bounce with prescale: lo=1, hi=3, div=1 → count 1,1,2,2,3,3,2,2,1,1,2,…; `period` pulses with each 1→2 turnaround; dir flips at 3 and 1.
- Degenerate and illegal limits:
  - lo=hi=7, mode 1 → count fixed at 7, `period` every cycle (div=0), busy=1.
  - lo=9, hi=4, start → `err` 1 cycle, busy stays 0.
- Boundary: WIDTH=8, lo=253, hi=255, mode 1 → 253,254,255,254,253,254; never 0.
- Stop, start and rst interactions:
  - stop at count=4 while UP → IDLE next cycle, count 4, no `done`.
  - start+stop together in IDLE → no effect.
  - start while busy → ignored.
  - rst mid-sweep → all outputs at reset values next cycle.
- Config handshake:
  - cfg_valid held while busy → cfg_ready=0 until the cycle after `done`, then accepted.
  - cfg+start in the same IDLE cycle → sweep uses the new lo.
